// File: rtl/range_link_pkg.sv
// range_link_pkg -- shared definitions for the range link transmitter.
//   state_t    : transmitter frame states, also visible on range_tx.state_dbg
//   *_WORD     : fixed 10-bit link words sent in the framing states
//   FIFO_DEPTH : number of sample entries buffered ahead of a frame
package range_link_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      GO   = 3'd1,
      DATA = 3'd2,
      FIN  = 3'd3,
      GAP  = 3'd4
   } state_t;

   localparam logic [9:0] IDLE_WORD  = 10'h000;
   localparam logic [9:0] GO_WORD    = 10'h001;
   localparam logic [9:0] FIN_WORD   = 10'h002;
   localparam int         FIFO_DEPTH = 8;

endpackage

// File: rtl/range_tx_fifo.sv
// range_tx_fifo -- 8 x 8-bit show-ahead FIFO feeding the range transmitter.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, wr_data: write request and data; a push while full is dropped
//   pop          : read request; a pop while empty is ignored
//   rd_data      : head entry, valid whenever count != 0
//   count        : number of stored entries (0..8)
//   full         : count == 8
module range_tx_fifo
   import range_link_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] wr_data,
   input  logic       pop,
   output logic [7:0] rd_data,
   output logic [3:0] count,
   output logic       full
);

   logic [7:0] mem [FIFO_DEPTH];
   logic [2:0] wr_ptr;
   logic [2:0] rd_ptr;
   logic       do_push;
   logic       do_pop;

   assign full    = (count == 4'(FIFO_DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && (count != 4'd0);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 3'd1;
         if (do_pop)  rd_ptr <= rd_ptr + 3'd1;
         // Simultaneous push and pop leaves the count unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/range_tx.sv
// range_tx -- buffers 8-bit samples and sends them as a framed burst on a
// 12-bit link, then captures the receiver's range reply.
// Frame: GO word, N sample words, FIN word, one GAP cycle (done pulse).
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready : sample handshake; in_data
//   send              : level-sampled frame request (ignored while busy/empty)
//   tx_out[11:2]      : registered link word, tx_out[1:0] always 0
//   rx_in             : receiver return, [9:0] range, [11] error
//   busy, done        : frame in progress / one-cycle pulse after FIN
//   rx_range, rx_err  : receiver reply captured on the FIN edge
//   exp_range,mismatch: only with RANGE_TX_CHECK_EN -- max-min of the sent
//                       sample words and whether rx_in[9:0] disagrees with it
//   state_dbg         : current FSM state (state_t encoding)
module range_tx
   import range_link_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic        send,
   output logic [11:0] tx_out,
   input  logic [11:0] rx_in,
   output logic        busy,
   output logic        done,
   output logic [9:0]  rx_range,
   output logic        rx_err,
`ifdef RANGE_TX_CHECK_EN
   output logic [9:0]  exp_range,
   output logic        mismatch,
`endif
   output logic [2:0]  state_dbg
);

   state_t     state;
   logic [3:0] rem;
   logic [3:0] fifo_count;
   logic       fifo_full;
   logic [7:0] head;
   logic [9:0] head_word;
   logic       push;
   logic       pop;
   logic       unused_bits;

   // Handshake: a sample transfers on a rising edge where in_valid and
   // in_ready are both 1; in_ready depends only on FIFO occupancy.
   assign in_ready    = !fifo_full;
   assign push        = in_valid && in_ready;
   assign head_word   = {head, 2'b00};
   assign busy        = (state != IDLE);
   assign state_dbg   = state;
   assign unused_bits = rx_in[10];

   // The head is consumed on the edge that puts it on tx_out: the GO edge
   // loads the first word, each DATA edge with rem != 0 loads the next.
   assign pop = (state == GO) || ((state == DATA) && (rem != 4'd0));

   range_tx_fifo u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .wr_data (in_data),
      .pop     (pop),
      .rd_data (head),
      .count   (fifo_count),
      .full    (fifo_full)
   );

   // tx_out is loaded on each transition with the word of the state being
   // entered, so the word is on the link for exactly that state's cycles.
   // rem holds the samples still to be popped; it is latched from the FIFO
   // count on GO entry so later pushes wait for the next frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rem      <= '0;
         tx_out   <= '0;
         done     <= 1'b0;
         rx_range <= '0;
         rx_err   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (send && (fifo_count != 4'd0)) begin
                  state  <= GO;
                  rem    <= fifo_count;
                  tx_out <= {GO_WORD, 2'b00};
               end
            end
            GO: begin
               state  <= DATA;
               rem    <= rem - 4'd1;
               tx_out <= {head_word, 2'b00};
            end
            DATA: begin
               if (rem != 4'd0) begin
                  rem    <= rem - 4'd1;
                  tx_out <= {head_word, 2'b00};
               end else begin
                  state  <= FIN;
                  tx_out <= {FIN_WORD, 2'b00};
               end
            end
            FIN: begin
               state    <= GAP;
               rx_range <= rx_in[9:0];
               rx_err   <= rx_in[11];
               tx_out   <= {IDLE_WORD, 2'b00};
               done     <= 1'b1;
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               tx_out <= '0;
            end
         endcase
      end
   end

`ifdef RANGE_TX_CHECK_EN
   logic [9:0] max_q;
   logic [9:0] min_q;
   logic [9:0] span;

   assign span = max_q - min_q;

   // On GO the trackers restart from 0 / 3FF; the first word is folded in on
   // that same edge, which reduces to loading it into both.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         max_q     <= 10'h000;
         min_q     <= 10'h3FF;
         exp_range <= '0;
         mismatch  <= 1'b0;
      end else begin
         case (state)
            GO: begin
               max_q <= head_word;
               min_q <= head_word;
            end
            DATA: begin
               if (rem != 4'd0) begin
                  if (head_word > max_q) max_q <= head_word;
                  if (head_word < min_q) min_q <= head_word;
               end
            end
            FIN: begin
               exp_range <= span;
               mismatch  <= (rx_in[9:0] != span);
            end
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: doc/range_tx.md
RANGE_TX -- requirements
Module: range_tx

Interface
REQ-001 SHALL have port clock input 1: rising-edge clock.
REQ-002 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid input 1: sample offered.
REQ-004 SHALL have port in_ready output 1: buffer can accept a sample.
REQ-005 SHALL have port in_data input 8: sample value.
REQ-006 SHALL have port send input 1: start-frame request, level-sampled.
REQ-007 SHALL have port tx_out output 12: link word; [11:2] word, [1:0] tied 0.
REQ-008 SHALL have port rx_in input 12: receiver return; [9:0] range, [11] error.
REQ-009 SHALL have port busy output 1: frame in progress.
REQ-010 SHALL have port done output 1: one-cycle pulse in the cycle after FIN.
REQ-011 SHALL have port rx_range output 10: range captured in FIN.
REQ-012 SHALL have port rx_err output 1: rx_in[11] captured in FIN.

Function
REQ-013 SHALL buffer samples in an 8-entry FIFO; push when in_valid and in_ready; in_ready = not full.
REQ-014 SHALL use states IDLE, GO, DATA, FIN, GAP, one state per cycle except DATA.
REQ-015 IDLE: tx word 10'h000; go to GO when send=1 and FIFO count>=1; otherwise stay.
REQ-016 GO: tx word 10'h001, one cycle; then DATA.
REQ-017 DATA: pop one sample per cycle, tx word {sample,2'b00}; frame length = FIFO count latched on GO entry (N, 1..8); after N pops go to FIN.
REQ-018 Samples pushed during a frame SHALL NOT join the current frame; they are counted for the next one.
REQ-019 FIN: tx word 10'h002, one cycle; capture rx_in[9:0] into rx_range and rx_in[11] into rx_err on the FIN clock edge; then GAP.
REQ-020 GAP: tx word 10'h000 for one cycle; done=1 for that cycle; then IDLE.
REQ-021 busy SHALL be 1 in GO, DATA, FIN and GAP.
REQ-022 Push while full SHALL be dropped with no state change.
REQ-023 Simultaneous push and pop in DATA SHALL keep the count unchanged.
REQ-024 send while busy SHALL be ignored.
REQ-025 send with an empty FIFO SHALL be ignored.
REQ-026 tx_out SHALL be driven from registers, with no combinational path from inputs.

Reset
REQ-027 Reset SHALL take the block to IDLE.
REQ-028 Reset SHALL clear the FIFO pointers and count.
REQ-029 Reset values: tx_out=0, busy=0, done=0, rx_range=0, rx_err=0, in_ready=1.
REQ-030 Reset mid-frame SHALL abort the frame, with tx_out=0 from the reset assertion onward.

Configuration
REQ-031 Macro RANGE_TX_CHECK_EN, when defined, SHALL add outputs exp_range (10) and mismatch (1).
REQ-032 With RANGE_TX_CHECK_EN, the block SHALL track max/min of the DATA words sent.
REQ-033 With RANGE_TX_CHECK_EN, at FIN it SHALL register exp_range = max-min and mismatch = (rx_in[9:0] != max-min).
REQ-034 With RANGE_TX_CHECK_EN, max SHALL reset to 0 and min to 10'h3FF at GO.
REQ-035 Without RANGE_TX_CHECK_EN, these ports and that logic SHALL be absent.

Structure
REQ-036 Package range_link_pkg SHALL hold the state enum and the constants GO_WORD=10'h001, FIN_WORD=10'h002, IDLE_WORD=10'h000, FIFO_DEPTH=8.
REQ-037 The FIFO SHALL be sub-module range_tx_fifo (8x8, count output).

Verification
REQ-038 Push 8'h10, 8'h40, 8'h05, then pulse send -> tx sequence 001, 040, 100, 014, 002, 000; done pulses once.
REQ-039 With rx_in[9:0]=10'h0EC during FIN -> rx_range=10'h0EC; with CHECK_EN, exp_range=10'h0EC and mismatch=0.
REQ-040 Push 9 samples -> in_ready=0 after the 8th; the 9th is dropped; frame carries exactly 8 DATA words.
REQ-041 send with an empty FIFO -> stays IDLE, busy=0, tx_out=0.
REQ-042 Push 2 samples during DATA of a 3-sample frame -> frame has 3 DATA words; the next send yields a frame with 2.
REQ-043 Assert reset during DATA -> tx_out=0 and busy=0 immediately; FIFO empty; in_ready=1.
